// File: rtl/hazard_ctrl.sv
// Hazard and pipeline-control unit for the 5-stage RV32 core: E-stage forwarding,
// load-use/RAW stalls, branch flushes, a multi-cycle-op freeze FSM and perf counters.
module hazard_ctrl #(
   parameter int REG_AW = 5,
   parameter int MC_LAT = 4,
   parameter int FWD_EN = 1,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic              reg_write_e,
   input  logic [1:0]        result_src_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic              reg_write_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_w,
   input  logic              pc_src_e,
   input  logic              mc_start_e,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              flush_d,
   output logic              flush_e,
   output logic              flush_m,
   output logic              mc_busy,
   output logic              mc_done,
   output logic [CNT_W-1:0]  stall_cycles,
   output logic [CNT_W-1:0]  flush_events
);

   localparam int CW = $clog2(MC_LAT) + 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(MC_LAT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   typedef enum logic {IDLE, BUSY} mc_state_t;

   mc_state_t     state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic          mc_stall;
   logic [1:0]    fwd_a, fwd_b;
   logic          load_use, rs1_d_hit, rs2_d_hit, raw, hz_stall;

   // Memory stage has the younger value, so it wins over writeback.
   always_comb begin
      fwd_a = 2'b00;
      fwd_b = 2'b00;
      if (reg_write_m && rd_m != '0 && rd_m == rs1_e)
         fwd_a = 2'b10;
      else if (reg_write_w && rd_w != '0 && rd_w == rs1_e)
         fwd_a = 2'b01;
      if (reg_write_m && rd_m != '0 && rd_m == rs2_e)
         fwd_b = 2'b10;
      else if (reg_write_w && rd_w != '0 && rd_w == rs2_e)
         fwd_b = 2'b01;
   end

   assign forward_a_e = (FWD_EN != 0) ? fwd_a : 2'b00;
   assign forward_b_e = (FWD_EN != 0) ? fwd_b : 2'b00;

   assign load_use  = (result_src_e == 2'b01) && (rd_e != '0) && (rd_e == rs1_d || rd_e == rs2_d);
   assign rs1_d_hit = (rs1_d != '0) && ((reg_write_e && rd_e == rs1_d) ||
                      (reg_write_m && rd_m == rs1_d) || (reg_write_w && rd_w == rs1_d));
   assign rs2_d_hit = (rs2_d != '0) && ((reg_write_e && rd_e == rs2_d) ||
                      (reg_write_m && rd_m == rs2_d) || (reg_write_w && rd_w == rs2_d));
   assign raw       = rs1_d_hit || rs2_d_hit;
   // A taken branch squashes the dependent instruction anyway, so it cancels the data stall.
   assign hz_stall  = ((FWD_EN != 0) ? load_use : raw) && !pc_src_e;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (mc_start_e && (MC_LAT > 1)) begin
               state_next = BUSY;
               cnt_next   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt > CNT_ONE) begin
               cnt_next = cnt - CNT_ONE;
            end else begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      mc_stall = 1'b0;
      mc_done  = 1'b0;
      case (state)
         IDLE: begin
            mc_stall = mc_start_e && (MC_LAT > 1);
            mc_done  = mc_start_e && (MC_LAT == 1);
         end
         BUSY: begin
            mc_stall = cnt > CNT_ONE;
            mc_done  = cnt == CNT_ONE;
         end
         default: ;
      endcase
   end

   assign mc_busy = (state == BUSY);
   assign stall_f = hz_stall || mc_stall;
   assign stall_d = hz_stall || mc_stall;
   assign stall_e = mc_stall;
   assign flush_d = pc_src_e;
   assign flush_e = pc_src_e || (hz_stall && !mc_stall);
   assign flush_m = mc_stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (stall_f && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (pc_src_e && flush_events != '1)
            flush_events <= flush_events + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: fixed vector table, hand sequences for the
// multi-cycle op and mid-op reset, and random traffic against a cycle-level model.
module tb_hazard_ctrl;

   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic       reg_write_e, reg_write_m, reg_write_w, pc_src_e, mc_start_e;
   logic [1:0] result_src_e;

   logic [1:0]  forward_a_e, forward_b_e, forward_a_nf, forward_b_nf, forward_a_l1, forward_b_l1;
   logic        stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy, mc_done;
   logic        stall_f_nf, stall_d_nf, stall_e_nf, flush_d_nf, flush_e_nf, flush_m_nf, mc_busy_nf, mc_done_nf;
   logic        stall_f_l1, stall_d_l1, stall_e_l1, flush_d_l1, flush_e_l1, flush_m_l1, mc_busy_l1, mc_done_l1;
   logic [31:0] stall_cycles, flush_events, stall_cycles_l1, flush_events_l1;
   logic [3:0]  stall_cycles_nf, flush_events_nf;

   always #5 clk = ~clk;

   hazard_ctrl #(.REG_AW(5), .MC_LAT(LAT), .FWD_EN(1), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e), .rd_m(rd_m),
      .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
      .mc_start_e(mc_start_e), .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .flush_d(flush_d),
      .flush_e(flush_e), .flush_m(flush_m), .mc_busy(mc_busy), .mc_done(mc_done),
      .stall_cycles(stall_cycles), .flush_events(flush_events));

   hazard_ctrl #(.REG_AW(5), .MC_LAT(LAT), .FWD_EN(0), .CNT_W(4)) dut_nf (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e), .rd_m(rd_m),
      .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
      .mc_start_e(mc_start_e), .forward_a_e(forward_a_nf), .forward_b_e(forward_b_nf),
      .stall_f(stall_f_nf), .stall_d(stall_d_nf), .stall_e(stall_e_nf), .flush_d(flush_d_nf),
      .flush_e(flush_e_nf), .flush_m(flush_m_nf), .mc_busy(mc_busy_nf), .mc_done(mc_done_nf),
      .stall_cycles(stall_cycles_nf), .flush_events(flush_events_nf));

   hazard_ctrl #(.REG_AW(5), .MC_LAT(1), .FWD_EN(1), .CNT_W(32)) dut_l1 (
      .clk(clk), .rst(rst), .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e),
      .rd_e(rd_e), .reg_write_e(reg_write_e), .result_src_e(result_src_e), .rd_m(rd_m),
      .reg_write_m(reg_write_m), .rd_w(rd_w), .reg_write_w(reg_write_w), .pc_src_e(pc_src_e),
      .mc_start_e(mc_start_e), .forward_a_e(forward_a_l1), .forward_b_e(forward_b_l1),
      .stall_f(stall_f_l1), .stall_d(stall_d_l1), .stall_e(stall_e_l1), .flush_d(flush_d_l1),
      .flush_e(flush_e_l1), .flush_m(flush_m_l1), .mc_busy(mc_busy_l1), .mc_done(mc_done_l1),
      .stall_cycles(stall_cycles_l1), .flush_events(flush_events_l1));

   typedef struct packed {
      logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e;
      logic       rw_e;
      logic [1:0] rsrc;
      logic [4:0] rd_m;
      logic       rw_m;
      logic [4:0] rd_w;
      logic       rw_w, pc;
      logic [1:0] fa, fb;
      logic       sf, fd, fe;
   } vec_t;

   typedef struct packed {
      logic [1:0] fa, fb;
      logic       sf, sd, se, fd, fe, fm, busy, done;
   } exp_t;

   int n_checks = 0;
   int n_fail   = 0;
   int k4;
   int sc4, scn, sc1, fe4, fen, fe1;
   vec_t tbl[12];

   task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [1:0] refFwd(input logic [4:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit pending(input logic [4:0] r);
      return r != 0 && ((reg_write_e && rd_e == r) || (reg_write_m && rd_m == r) ||
                        (reg_write_w && rd_w == r));
   endfunction

   // k is the cycle position of the op currently occupying E, -1 when none.
   function automatic exp_t refOut(input bit fwd_en, input int lat, input int k);
      exp_t e;
      bit   mcs, hz;
      mcs = (k >= 0) && (k < lat - 1);
      if (fwd_en)
         hz = result_src_e == 2'b01 && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      else
         hz = pending(rs1_d) || pending(rs2_d);
      hz     = hz && !pc_src_e;
      e.fa   = fwd_en ? refFwd(rs1_e) : 2'b00;
      e.fb   = fwd_en ? refFwd(rs2_e) : 2'b00;
      e.sf   = hz || mcs;
      e.sd   = hz || mcs;
      e.se   = mcs;
      e.fd   = pc_src_e;
      e.fe   = pc_src_e || (hz && !mcs);
      e.fm   = mcs;
      e.busy = k >= 1;
      e.done = k == lat - 1;
      return e;
   endfunction

   function automatic int curK();
      if (k4 == -1) return mc_start_e ? 0 : -1;
      return k4;
   endfunction

   task automatic cmpOut(input string tag, input exp_t act, input exp_t e);
      checkVal({tag, "_fwd_a"}, 32'(act.fa), 32'(e.fa));
      checkVal({tag, "_fwd_b"}, 32'(act.fb), 32'(e.fb));
      checkVal({tag, "_stall_f"}, 32'(act.sf), 32'(e.sf));
      checkVal({tag, "_stall_d"}, 32'(act.sd), 32'(e.sd));
      checkVal({tag, "_stall_e"}, 32'(act.se), 32'(e.se));
      checkVal({tag, "_flush_d"}, 32'(act.fd), 32'(e.fd));
      checkVal({tag, "_flush_e"}, 32'(act.fe), 32'(e.fe));
      checkVal({tag, "_flush_m"}, 32'(act.fm), 32'(e.fm));
      checkVal({tag, "_mc_busy"}, 32'(act.busy), 32'(e.busy));
      checkVal({tag, "_mc_done"}, 32'(act.done), 32'(e.done));
   endtask

   task automatic checkOutput(input string tag);
      int c4;
      c4 = curK();
      cmpOut({tag, "_fw"}, '{forward_a_e, forward_b_e, stall_f, stall_d, stall_e, flush_d,
             flush_e, flush_m, mc_busy, mc_done}, refOut(1'b1, LAT, c4));
      cmpOut({tag, "_nf"}, '{forward_a_nf, forward_b_nf, stall_f_nf, stall_d_nf, stall_e_nf,
             flush_d_nf, flush_e_nf, flush_m_nf, mc_busy_nf, mc_done_nf}, refOut(1'b0, LAT, c4));
      cmpOut({tag, "_l1"}, '{forward_a_l1, forward_b_l1, stall_f_l1, stall_d_l1, stall_e_l1,
             flush_d_l1, flush_e_l1, flush_m_l1, mc_busy_l1, mc_done_l1},
             refOut(1'b1, 1, mc_start_e ? 0 : -1));
      checkVal({tag, "_stall_cycles"}, stall_cycles, 32'(sc4));
      checkVal({tag, "_flush_events"}, flush_events, 32'(fe4));
      checkVal({tag, "_stall_cycles_nf"}, 32'(stall_cycles_nf), 32'(scn));
      checkVal({tag, "_flush_events_nf"}, 32'(flush_events_nf), 32'(fen));
      checkVal({tag, "_stall_cycles_l1"}, stall_cycles_l1, 32'(sc1));
      checkVal({tag, "_flush_events_l1"}, flush_events_l1, 32'(fe1));
   endtask

   task automatic advanceModel();
      int   c4;
      exp_t e, en, e1;
      c4 = curK();
      e  = refOut(1'b1, LAT, c4);
      en = refOut(1'b0, LAT, c4);
      e1 = refOut(1'b1, 1, mc_start_e ? 0 : -1);
      if (e.sf)  sc4++;
      if (en.sf) scn = (scn < 15) ? scn + 1 : 15;
      if (e1.sf) sc1++;
      if (pc_src_e) begin
         fe4++;
         fe1++;
         fen = (fen < 15) ? fen + 1 : 15;
      end
      k4 = (c4 == -1 || c4 == LAT - 1) ? -1 : c4 + 1;
   endtask

   task automatic resetModel();
      k4 = -1;
      sc4 = 0; scn = 0; sc1 = 0;
      fe4 = 0; fen = 0; fe1 = 0;
   endtask

   task automatic applyStimulus(input vec_t v);
      rs1_d = v.rs1_d;  rs2_d = v.rs2_d;  rs1_e = v.rs1_e;  rs2_e = v.rs2_e;
      rd_e  = v.rd_e;   reg_write_e = v.rw_e;  result_src_e = v.rsrc;
      rd_m  = v.rd_m;   reg_write_m = v.rw_m;
      rd_w  = v.rd_w;   reg_write_w = v.rw_w;
      pc_src_e = v.pc;  mc_start_e = 1'b0;
   endtask

   task automatic stepCycle(input string tag);
      @(negedge clk);
      checkOutput(tag);
      advanceModel();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // rs1_d rs2_d rs1_e rs2_e rd_e rw_e rsrc rd_m rw_m rd_w rw_w pc | fa fb sf fd fe
      tbl[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 2'b00, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 1'b0, 2'b00, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[3]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[4]  = '{5'd0, 5'd0, 5'd0, 5'd9, 5'd0, 1'b0, 2'b00, 5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0};
      tbl[5]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 1'b0, 2'b00, 5'd3, 1'b0, 5'd9, 1'b1, 1'b0, 2'b00, 2'b01, 1'b0, 1'b0, 1'b0};
      tbl[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 1'b1, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
      tbl[9]  = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1};
      tbl[10] = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};
      tbl[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 1'b1};

      applyStimulus('0);
      rst = 1'b1;
      resetModel();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      @(negedge clk);
      checkVal("reset_stall_f", 32'(stall_f), 32'd0);
      checkVal("reset_mc_busy", 32'(mc_busy), 32'd0);
      checkVal("reset_stall_cycles", stall_cycles, 32'd0);
      checkVal("reset_flush_events", flush_events, 32'd0);
      @(posedge clk);
      #1;
      stepCycle("reset");

      for (int i = 0; i < 12; i++) begin
         applyStimulus(tbl[i]);
         @(negedge clk);
         checkVal($sformatf("vec%0d_fwd_a", i), 32'(forward_a_e), 32'(tbl[i].fa));
         checkVal($sformatf("vec%0d_fwd_b", i), 32'(forward_b_e), 32'(tbl[i].fb));
         checkVal($sformatf("vec%0d_stall_f", i), 32'(stall_f), 32'(tbl[i].sf));
         checkVal($sformatf("vec%0d_stall_d", i), 32'(stall_d), 32'(tbl[i].sf));
         checkVal($sformatf("vec%0d_flush_d", i), 32'(flush_d), 32'(tbl[i].fd));
         checkVal($sformatf("vec%0d_flush_e", i), 32'(flush_e), 32'(tbl[i].fe));
         checkOutput($sformatf("vec%0d", i));
         advanceModel();
         @(posedge clk);
         #1;
      end
      applyStimulus('0);
      stepCycle("after_table");
      checkVal("table_stall_cycles", stall_cycles, 32'd2);
      checkVal("table_flush_events", flush_events, 32'd2);

      for (int c = 0; c < LAT; c++) begin
         mc_start_e = 1'b1;
         @(negedge clk);
         checkVal($sformatf("mc_c%0d_stall_e", c), 32'(stall_e), 32'(c < LAT - 1));
         checkVal($sformatf("mc_c%0d_flush_m", c), 32'(flush_m), 32'(c < LAT - 1));
         checkVal($sformatf("mc_c%0d_mc_done", c), 32'(mc_done), 32'(c == LAT - 1));
         checkVal($sformatf("mc_c%0d_mc_busy", c), 32'(mc_busy), 32'(c >= 1));
         checkOutput($sformatf("mc_c%0d", c));
         advanceModel();
         @(posedge clk);
         #1;
      end
      mc_start_e = 1'b0;
      stepCycle("mc_after");

      mc_start_e = 1'b1;
      stepCycle("rst_mc_c0");
      checkVal("rst_pre_busy", 32'(mc_busy), 32'd1);
      #1;
      mc_start_e = 1'b0;
      rst = 1'b1;
      #1;
      checkVal("rst_mc_busy", 32'(mc_busy), 32'd0);
      checkVal("rst_stall_f", 32'(stall_f), 32'd0);
      checkVal("rst_stall_e", 32'(stall_e), 32'd0);
      checkVal("rst_stall_cycles", stall_cycles, 32'd0);
      checkVal("rst_flush_events_nf", 32'(flush_events_nf), 32'd0);
      resetModel();
      #1 rst = 1'b0;
      stepCycle("rst_idle");
      for (int c = 0; c < LAT; c++) begin
         mc_start_e = 1'b1;
         stepCycle($sformatf("rst_restart%0d", c));
      end
      mc_start_e = 1'b0;

      applyStimulus('0);
      reg_write_m = 1'b1; rd_m = 5'd3; rs1_d = 5'd3; rs1_e = 5'd3; rs2_e = 5'd3;
      @(negedge clk);
      checkVal("nf_stall_f", 32'(stall_f_nf), 32'd1);
      checkVal("nf_stall_d", 32'(stall_d_nf), 32'd1);
      checkVal("nf_flush_e", 32'(flush_e_nf), 32'd1);
      checkVal("nf_fwd_a", 32'(forward_a_nf), 32'd0);
      checkVal("nf_fwd_b", 32'(forward_b_nf), 32'd0);
      checkVal("fw_fwd_a_m", 32'(forward_a_e), 32'd2);
      checkVal("fw_no_stall", 32'(stall_f), 32'd0);
      checkOutput("nf");
      advanceModel();
      @(posedge clk);
      #1;
      applyStimulus('0);
      reg_write_w = 1'b1; rd_w = 5'd0;
      stepCycle("nf_x0");

      for (int n = 0; n < 400; n++) begin
         rs1_d = 5'($urandom_range(0, 3));
         rs2_d = 5'($urandom_range(0, 3));
         rs1_e = 5'($urandom_range(0, 3));
         rs2_e = 5'($urandom_range(0, 3));
         rd_e  = 5'($urandom_range(0, 3));
         rd_m  = 5'($urandom_range(0, 3));
         rd_w  = 5'($urandom_range(0, 3));
         reg_write_e  = 1'($urandom_range(0, 1));
         reg_write_m  = 1'($urandom_range(0, 1));
         reg_write_w  = 1'($urandom_range(0, 1));
         result_src_e = 2'($urandom_range(0, 3));
         mc_start_e   = ($urandom_range(0, 7) == 0);
         pc_src_e     = (k4 == -1 && !mc_start_e) ? ($urandom_range(0, 3) == 0) : 1'b0;
         stepCycle($sformatf("rand%0d", n));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
